// File: rtl/spi_pkg.sv
// Shared state encoding and default sizing for the SPI burst slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_FETCH,
      ST_DATA,
      ST_DRAIN
   } spi_state_t;

   localparam int SPI_ADDR_W_DEF      = 7;
   localparam int SPI_DATA_W_DEF      = 32;
   localparam int SPI_SYNC_STAGES_DEF = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus a one-Clk-older copy for edge detection.
// Latency: STAGES Clk to sync_out, STAGES+1 Clk to prev_out.
// Backpressure: none; free-running every Clk.
//
// Ports: Clk, Reset_n (async, active-low), async_in (raw pin),
//        sync_out (synchronised level), prev_out (sync_out delayed by one Clk).
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
)(
   input  logic Clk,
   input  logic Reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic prev_out
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         chain    <= {STAGES{RST_VAL}};
         prev_out <= RST_VAL;
      end else begin
         chain    <= {chain[STAGES-2:0], async_in};
         prev_out <= chain[STAGES-1];
      end
   end

   assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_burst.sv
// SPI mode-0 slave that bursts words to/from a word-addressed RAM after an (ADDR_W+1)-bit header.
// Latency: SYNC_STAGES+1 Clk from an SPI pin edge to its effect; RAM_we one Clk after the last bit is seen.
// Backpressure: none; the SPI master paces everything, SPI_CLK must be no faster than Clk/8.
//
// Ports: Clk, Reset_n (async, active-low); SPI_CLK/SPI_CS/SPI_MOSI in, SPI_MISO out;
//        Data_Addr/Data_Read RAM read port, data_fromPI/RAM_we RAM write port;
//        Busy (CS asserted and frame accepted), Frame_err (one-Clk pulse on a truncated frame).
module spi_slave_burst
   import spi_pkg::*;
#(
   parameter int ADDR_W      = SPI_ADDR_W_DEF,
   parameter int DATA_W      = SPI_DATA_W_DEF,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
)(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              SPI_CLK,
   input  logic              SPI_CS,
   input  logic              SPI_MOSI,
   output logic              SPI_MISO,
   output logic [ADDR_W-1:0] Data_Addr,
   input  logic [DATA_W-1:0] Data_Read,
   output logic [DATA_W-1:0] data_fromPI,
   output logic              RAM_we,
   output logic              Busy,
   output logic              Frame_err
);

   localparam int SR_W  = max_int(ADDR_W + 1, DATA_W);
   localparam int CNT_W = $clog2(SR_W + 1);

   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

   spi_state_t state, state_nxt;

   logic              sclk_s, sclk_p, cs_s, cs_p, mosi_s, mosi_p;
   logic              sclk_rise, sclk_fall, cs_rise, cs_fall, sck_r, sck_f;
   logic              mosi_bit;
   logic [CNT_W-1:0]  cnt;
   logic [SR_W-1:0]   sh;
   logic              wr;
   logic              armed;
   logic [SYNC_STAGES:0] settle;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .Clk(Clk), .Reset_n(Reset_n), .async_in(SPI_CLK),  .sync_out(sclk_s), .prev_out(sclk_p));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .Clk(Clk), .Reset_n(Reset_n), .async_in(SPI_CS),   .sync_out(cs_s),   .prev_out(cs_p));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .Clk(Clk), .Reset_n(Reset_n), .async_in(SPI_MOSI), .sync_out(mosi_s), .prev_out(mosi_p));

   assign sclk_rise = sclk_s & ~sclk_p;
   assign sclk_fall = ~sclk_s & sclk_p;
   assign cs_rise   = cs_s & ~cs_p;
   assign cs_fall   = ~cs_s & cs_p;

   // A CS rise in the same Clk as an SCLK edge ends the frame; that edge is dropped.
   assign sck_r = sclk_rise & ~cs_rise;
   assign sck_f = sclk_fall & ~cs_rise;

   // MOSI is taken from the copy aligned with sclk_p, i.e. the last cycle SCLK was still low,
   // so a master that moves MOSI right at the rising edge still meets setup.
   assign mosi_bit = mosi_p;

   assign Busy   = (state != ST_IDLE);
   assign RAM_we = (state == ST_DRAIN);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (armed && cs_fall) state_nxt = ST_HDR;
         // The W bit was the first header bit, so it sits at sh[ADDR_W-1] when the last bit arrives.
         ST_HDR:   if (sck_r && cnt == HDR_LAST) state_nxt = sh[ADDR_W-1] ? ST_DATA : ST_FETCH;
         ST_FETCH: state_nxt = ST_DATA;
         ST_DATA:  if (sck_r && cnt == WORD_LAST) state_nxt = wr ? ST_DRAIN : ST_FETCH;
         ST_DRAIN: state_nxt = ST_DATA;
         default:  state_nxt = ST_IDLE;
      endcase
      if (cs_rise) state_nxt = ST_IDLE;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         sh          <= '0;
         wr          <= 1'b0;
         armed       <= 1'b0;
         settle      <= '0;
         Data_Addr   <= '0;
         data_fromPI <= '0;
         SPI_MISO    <= 1'b0;
         Frame_err   <= 1'b0;
      end else begin
         state <= state_nxt;

         // The CS synchroniser comes out of reset preset high; only once it has flushed and
         // shows CS high for real do we accept a falling edge. A frame in progress
         // across reset is therefore ignored until CS deasserts.
         settle <= {settle[SYNC_STAGES-1:0], 1'b1};
         if (settle[SYNC_STAGES] && cs_s) armed <= 1'b1;

         Frame_err <= cs_rise && ((state == ST_HDR) || (state == ST_DATA && cnt != '0));

         if (cs_rise) SPI_MISO <= 1'b0;

         case (state)
            ST_IDLE: begin
               SPI_MISO <= 1'b0;
               if (state_nxt == ST_HDR) begin
                  cnt <= '0;
                  sh  <= '0;
               end
            end
            ST_HDR: begin
               if (sck_r) begin
                  sh <= {sh[SR_W-2:0], mosi_bit};
                  if (cnt == HDR_LAST) begin
                     cnt       <= '0;
                     wr        <= sh[ADDR_W-1];
                     Data_Addr <= {sh[ADDR_W-2:0], mosi_bit};
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            // Data_Read has had a full Clk to follow the new Data_Addr.
            ST_FETCH: sh <= SR_W'(Data_Read);
            ST_DATA: begin
               if (wr) begin
                  if (sck_r) begin
                     sh <= {sh[SR_W-2:0], mosi_bit};
                     if (cnt == WORD_LAST) begin
                        cnt         <= '0;
                        data_fromPI <= {sh[DATA_W-2:0], mosi_bit};
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end else begin
                  if (sck_f) begin
                     SPI_MISO <= sh[DATA_W-1];
                     sh       <= sh << 1;
                  end
                  if (sck_r) begin
                     if (cnt == WORD_LAST) begin
                        cnt       <= '0;
                        Data_Addr <= Data_Addr + 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
            end
            // RAM_we is high during this state; the address moves on as it ends.
            ST_DRAIN: Data_Addr <= Data_Addr + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Self-checking bench for spi_slave_burst: default-size instance plus an ADDR_W=4/DATA_W=16 instance.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_spi_slave_burst;

   localparam int HALF = 160;   // SCLK half period = 8 Clk periods

   logic        Clk, Reset_n, sclk, mosi, cs0, cs1;
   logic        miso0, miso1, we0, we1, busy0, busy1, ferr0, ferr1;
   logic [6:0]  addr0;
   logic [3:0]  addr1;
   logic [31:0] rd0, dfp0;
   logic [15:0] rd1, dfp1;

   logic [31:0] ram0 [0:127];
   logic [15:0] ram1 [0:15];
   assign rd0 = ram0[addr0];
   assign rd1 = ram1[addr1];

   spi_slave_burst u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .SPI_CLK(sclk), .SPI_CS(cs0), .SPI_MOSI(mosi),
      .SPI_MISO(miso0), .Data_Addr(addr0), .Data_Read(rd0), .data_fromPI(dfp0),
      .RAM_we(we0), .Busy(busy0), .Frame_err(ferr0));

   spi_slave_burst #(.ADDR_W(4), .DATA_W(16)) u_dut16 (
      .Clk(Clk), .Reset_n(Reset_n), .SPI_CLK(sclk), .SPI_CS(cs1), .SPI_MOSI(mosi),
      .SPI_MISO(miso1), .Data_Addr(addr1), .Data_Read(rd1), .data_fromPI(dfp1),
      .RAM_we(we1), .Busy(busy1), .Frame_err(ferr1));

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Observed bus activity
   logic [38:0] obs0 [$];
   logic [19:0] obs1 [$];
   int          err0 = 0, err1 = 0, inc_bad = 0;
   logic        we0_d = 1'b0;
   logic [6:0]  addr0_d = '0;

   always @(negedge Clk) begin
      if (we0) obs0.push_back({addr0, dfp0});
      if (we1) obs1.push_back({addr1, dfp1});
      if (ferr0) err0++;
      if (ferr1) err1++;
      if (we0_d && addr0 !== 7'(addr0_d + 7'd1)) inc_bad++;
      we0_d   = we0;
      addr0_d = addr0;
   end

   // Frame data shared by the frame task and the tests
   logic [31:0] fw [0:7];
   logic [31:0] fr [0:7];
   int          miso_hi;

   // Reference model: n-th word of a burst at start address a lands at (a+n) mod 2^ADDR_W.
   function automatic logic [38:0] exp_wr0(input logic [6:0] a, input int i, input logic [31:0] d);
      return {7'((int'(a) + i) % 128), d};
   endfunction

   task automatic spi_bit(input bit sel, input logic b, output logic r);
      mosi = b;
      #(HALF);
      r = sel ? miso1 : miso0;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
   endtask

   task automatic spi_word(input bit sel, input logic [31:0] v, input int n, output logic [31:0] r);
      logic b;
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_bit(sel, v[i], b);
         r = {r[30:0], b};
      end
   endtask

   task automatic cs_assert(input bit sel);
      if (sel) cs1 = 1'b0; else cs0 = 1'b0;
      #(HALF);
   endtask

   task automatic cs_release(input bit sel);
      #(HALF);
      if (sel) cs1 = 1'b1; else cs0 = 1'b1;
      repeat (12) @(negedge Clk);
   endtask

   task automatic run_frame0(input bit w, input logic [6:0] a, input int n);
      logic [31:0] r;
      obs0.delete();
      err0    = 0;
      miso_hi = 0;
      cs_assert(1'b0);
      spi_word(1'b0, {24'd0, w, a}, 8, r);
      if (r !== 32'd0) miso_hi++;
      for (int i = 0; i < n; i++) begin
         if (w) begin
            spi_word(1'b0, fw[i], 32, r);
            if (r !== 32'd0) miso_hi++;
         end else begin
            spi_word(1'b0, 32'd0, 32, r);
            fr[i] = r;
         end
      end
      cs_release(1'b0);
   endtask

   task automatic test_reset;
      #5;
      n_checks++; if (miso0 !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso0); else n_pass++;
      n_checks++; if (addr0 !== 7'd0) $display("FAIL reset_addr: got %h want 00", addr0); else n_pass++;
      n_checks++; if (dfp0 !== 32'd0) $display("FAIL reset_data: got %h want 0", dfp0); else n_pass++;
      n_checks++; if ({we0, busy0, ferr0} !== 3'b000)
         $display("FAIL reset_strobes: got we/busy/err=%b want 000", {we0, busy0, ferr0}); else n_pass++;
      n_checks++; if ({busy1, we1, addr1} !== 6'd0)
         $display("FAIL reset_dut16: got %b want 0", {busy1, we1, addr1}); else n_pass++;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (10) @(negedge Clk);
      n_checks++; if (busy0 !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy0); else n_pass++;
   endtask

   task automatic test_write_burst;
      fw[0] = 32'hDEADBEEF;
      fw[1] = 32'h12345678;
      run_frame0(1'b1, 7'h05, 2);
      n_checks++; if (obs0.size() !== 2) $display("FAIL wr_count: got %0d want 2", obs0.size()); else n_pass++;
      for (int i = 0; i < 2 && i < obs0.size(); i++) begin
         n_checks++;
         if (obs0[i] !== exp_wr0(7'h05, i, fw[i]))
            $display("FAIL wr_entry%0d: got %h want %h", i, obs0[i], exp_wr0(7'h05, i, fw[i]));
         else n_pass++;
      end
      n_checks++; if (dfp0 !== fw[1]) $display("FAIL wr_last_word: got %h want %h", dfp0, fw[1]); else n_pass++;
      n_checks++; if (err0 !== 0) $display("FAIL wr_frame_err: got %0d want 0", err0); else n_pass++;
      n_checks++; if (miso_hi !== 0) $display("FAIL wr_miso_quiet: got %0d want 0", miso_hi); else n_pass++;
      n_checks++; if (inc_bad !== 0) $display("FAIL wr_addr_step: got %0d want 0", inc_bad); else n_pass++;
   endtask

   task automatic test_read_burst;
      ram0[16] = 32'hCAFEF00D;
      ram0[17] = 32'h0BADC0DE;
      run_frame0(1'b0, 7'h10, 2);
      n_checks++; if (fr[0] !== 32'hCAFEF00D) $display("FAIL rd_word0: got %h want cafef00d", fr[0]); else n_pass++;
      n_checks++; if (fr[1] !== 32'h0BADC0DE) $display("FAIL rd_word1: got %h want 0badc0de", fr[1]); else n_pass++;
      n_checks++; if (obs0.size() !== 0) $display("FAIL rd_no_write: got %0d want 0", obs0.size()); else n_pass++;
      n_checks++; if (err0 !== 0) $display("FAIL rd_frame_err: got %0d want 0", err0); else n_pass++;
      n_checks++; if (miso_hi !== 0) $display("FAIL rd_hdr_miso: got %0d want 0", miso_hi); else n_pass++;
      n_checks++; if ({miso0, busy0} !== 2'b00) $display("FAIL rd_end_idle: got %b want 00", {miso0, busy0}); else n_pass++;
   endtask

   task automatic test_wrap;
      fw[0] = $urandom;
      fw[1] = $urandom;
      run_frame0(1'b1, 7'h7F, 2);
      n_checks++; if (obs0.size() !== 2) $display("FAIL wrap_count: got %0d want 2", obs0.size()); else n_pass++;
      n_checks++; if (obs0.size() > 0 && obs0[0] !== {7'h7F, fw[0]})
         $display("FAIL wrap_first: got %h want %h", obs0[0], {7'h7F, fw[0]}); else n_pass++;
      n_checks++; if (obs0.size() > 1 && obs0[1] !== {7'h00, fw[1]})
         $display("FAIL wrap_second: got %h want %h", obs0[1], {7'h00, fw[1]}); else n_pass++;
   endtask

   task automatic test_abort;
      logic [31:0] r;
      obs0.delete();
      err0 = 0;
      cs_assert(1'b0);
      spi_word(1'b0, 32'h82, 8, r);
      spi_word(1'b0, $urandom, 17, r);
      cs_release(1'b0);
      n_checks++; if (err0 !== 1) $display("FAIL abort_data_err: got %0d pulses want 1", err0); else n_pass++;
      n_checks++; if (obs0.size() !== 0) $display("FAIL abort_no_write: got %0d want 0", obs0.size()); else n_pass++;
      n_checks++; if (busy0 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy0); else n_pass++;
      err0 = 0;
      cs_assert(1'b0);
      spi_word(1'b0, 32'h8, 4, r);
      cs_release(1'b0);
      n_checks++; if (err0 !== 1) $display("FAIL abort_hdr_err: got %0d pulses want 1", err0); else n_pass++;
   endtask

   task automatic test_zero_word;
      run_frame0(1'b1, 7'h0A, 0);
      n_checks++; if (obs0.size() !== 0) $display("FAIL zero_wr_count: got %0d want 0", obs0.size()); else n_pass++;
      n_checks++; if (err0 !== 0) $display("FAIL zero_wr_err: got %0d want 0", err0); else n_pass++;
      run_frame0(1'b0, 7'h33, 0);
      n_checks++; if (err0 !== 0) $display("FAIL zero_rd_err: got %0d want 0", err0); else n_pass++;
   endtask

   task automatic test_reset_midframe;
      logic [31:0] r;
      obs0.delete();
      cs_assert(1'b0);
      spi_word(1'b0, 32'h85, 8, r);
      spi_word(1'b0, 32'h13579BDF, 32, r);
      spi_word(1'b0, $urandom, 10, r);
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      n_checks++; if (dfp0 !== 32'd0) $display("FAIL rst_mid_data: got %h want 0", dfp0); else n_pass++;
      n_checks++; if (addr0 !== 7'd0) $display("FAIL rst_mid_addr: got %h want 00", addr0); else n_pass++;
      n_checks++; if ({busy0, we0, ferr0, miso0} !== 4'b0000)
         $display("FAIL rst_mid_strobes: got %b want 0000", {busy0, we0, ferr0, miso0}); else n_pass++;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      obs0.delete();
      err0 = 0;
      spi_word(1'b0, $urandom, 22, r);
      spi_word(1'b0, $urandom, 32, r);
      n_checks++; if (obs0.size() !== 0) $display("FAIL rst_mid_ignored: got %0d writes want 0", obs0.size()); else n_pass++;
      n_checks++; if (busy0 !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy0); else n_pass++;
      cs_release(1'b0);
      n_checks++; if (err0 !== 0) $display("FAIL rst_mid_err: got %0d want 0", err0); else n_pass++;
      fw[0] = $urandom;
      run_frame0(1'b1, 7'h05, 1);
      n_checks++; if (obs0.size() !== 1 || obs0[0] !== {7'h05, fw[0]})
         $display("FAIL rst_mid_recover: got %0d writes want 1 at 05 data %h", obs0.size(), fw[0]); else n_pass++;
   endtask

   task automatic test_param_sweep;
      logic [31:0] r;
      logic [15:0] w2;
      w2 = 16'($urandom);
      obs1.delete();
      err1 = 0;
      cs_assert(1'b1);
      spi_word(1'b1, 32'h13, 5, r);
      spi_word(1'b1, 32'hA5A5, 16, r);
      spi_word(1'b1, {16'd0, w2}, 16, r);
      cs_release(1'b1);
      n_checks++; if (obs1.size() !== 2) $display("FAIL sweep_count: got %0d want 2", obs1.size()); else n_pass++;
      n_checks++; if (obs1.size() > 0 && obs1[0] !== {4'h3, 16'hA5A5})
         $display("FAIL sweep_first: got %h want 3a5a5", obs1[0]); else n_pass++;
      n_checks++; if (obs1.size() > 1 && obs1[1] !== {4'h4, w2})
         $display("FAIL sweep_second: got %h want %h", obs1[1], {4'h4, w2}); else n_pass++;
      n_checks++; if (err1 !== 0) $display("FAIL sweep_err: got %0d want 0", err1); else n_pass++;
   endtask

   task automatic test_random;
      bit          w;
      logic [6:0]  a;
      int          n;
      for (int j = 0; j < 128; j++) ram0[j] = $urandom;
      for (int f = 0; f < 6; f++) begin
         w = 1'($urandom_range(0, 1));
         a = 7'($urandom_range(0, 127));
         n = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) fw[i] = $urandom;
         run_frame0(w, a, n);
         n_checks++; if (err0 !== 0) $display("FAIL rand%0d_err: got %0d want 0", f, err0); else n_pass++;
         if (w) begin
            n_checks++; if (obs0.size() !== n)
               $display("FAIL rand%0d_wr_count: got %0d want %0d", f, obs0.size(), n); else n_pass++;
            for (int i = 0; i < n && i < obs0.size(); i++) begin
               n_checks++;
               if (obs0[i] !== exp_wr0(a, i, fw[i]))
                  $display("FAIL rand%0d_wr%0d: got %h want %h", f, i, obs0[i], exp_wr0(a, i, fw[i]));
               else n_pass++;
            end
         end else begin
            for (int i = 0; i < n; i++) begin
               n_checks++;
               if (fr[i] !== ram0[(int'(a) + i) % 128])
                  $display("FAIL rand%0d_rd%0d: got %h want %h", f, i, fr[i], ram0[(int'(a) + i) % 128]);
               else n_pass++;
            end
         end
      end
   endtask

   initial begin
      Reset_n = 1'b0;
      cs0 = 1'b1;
      cs1 = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      for (int j = 0; j < 128; j++) ram0[j] = '0;
      for (int j = 0; j < 16; j++) ram1[j] = '0;
      test_reset;
      test_write_burst;
      test_read_burst;
      test_wrap;
      test_abort;
      test_zero_word;
      test_reset_midframe;
      test_param_sweep;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
